// File: rtl/ref_line_builder.sv
// Builds a block of N_ROWS+1 edge-padded reference lines from incoming rows:
// each line gets sample 0 replicated on its left, and row 0 is emitted twice (top edge).
module ref_line_builder #(
    parameter int SAMPLE_W = 8,
    parameter int N_COLS   = 8,
    parameter int N_ROWS   = 8
) (
    input  logic                           CLK,
    input  logic                           RST_ASYNC,
    input  logic                           START,
    input  logic [N_COLS*SAMPLE_W-1:0]     ROW_IN,
    input  logic                           ROW_VALID,
    output logic                           ROW_READY,
    output logic [(N_COLS+1)*SAMPLE_W-1:0] LINE_OUT,
    output logic                           LINE_WE,
    output logic [3:0]                     LINE_IDX,
    output logic                           BUSY,
    output logic                           DONE
);

    localparam int ROW_W  = N_COLS * SAMPLE_W;
    localparam int LINE_W = (N_COLS + 1) * SAMPLE_W;
    localparam logic [3:0] LAST_ROW = 4'(N_ROWS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_REPEAT = 3'd2;
    localparam logic [2:0] S_ROWS   = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_rowCnt;
    logic [ROW_W-1:0]  r_buf;
    logic [LINE_W-1:0] r_lineOut;
    logic              r_lineWe;
    logic [3:0]        r_lineIdx;
    logic              r_done;

    logic              w_rowReady;
    logic              w_hs;
    logic [LINE_W-1:0] w_padRow;
    logic [LINE_W-1:0] w_padBuf;

    assign w_rowReady = (r_state == S_FIRST) || (r_state == S_ROWS);
    assign w_hs       = ROW_VALID && w_rowReady;
    assign w_padRow   = {ROW_IN[ROW_W-1 -: SAMPLE_W], ROW_IN};
    assign w_padBuf   = {r_buf[ROW_W-1 -: SAMPLE_W], r_buf};

    // DONE is registered so it lands the cycle after the last line; START is
    // refused during that cycle even though the FSM is already back in IDLE.
    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_state   <= S_IDLE;
            r_rowCnt  <= 4'd0;
            r_buf     <= '0;
            r_lineOut <= '0;
            r_lineWe  <= 1'b0;
            r_lineIdx <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_lineWe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START && !r_done) begin
                        r_state  <= S_FIRST;
                        r_rowCnt <= 4'd0;
                    end
                end
                S_FIRST: begin
                    if (w_hs) begin
                        r_buf     <= ROW_IN;
                        r_lineOut <= w_padRow;
                        r_lineIdx <= 4'd0;
                        r_lineWe  <= 1'b1;
                        r_state   <= S_REPEAT;
                        if (r_rowCnt != LAST_ROW) begin
                            r_rowCnt <= r_rowCnt + 4'd1;
                        end
                    end
                end
                S_REPEAT: begin
                    r_lineOut <= w_padBuf;
                    r_lineIdx <= 4'd1;
                    r_lineWe  <= 1'b1;
                    r_state   <= (LAST_ROW == 4'd0) ? S_FIN : S_ROWS;
                end
                S_ROWS: begin
                    if (w_hs) begin
                        r_lineOut <= w_padRow;
                        r_lineIdx <= r_rowCnt + 4'd1;
                        r_lineWe  <= 1'b1;
                        if (r_rowCnt == LAST_ROW) begin
                            r_state <= S_FIN;
                        end else begin
                            r_rowCnt <= r_rowCnt + 4'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ROW_READY = w_rowReady;
    assign LINE_OUT  = r_lineOut;
    assign LINE_WE   = r_lineWe;
    assign LINE_IDX  = r_lineIdx;
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = r_done;

endmodule

// File: tb/tb_ref_line_builder.sv
// Directed bench for ref_line_builder at default parameters: line content and
// order, stalls, ignored START/ROW_VALID, and asynchronous reset mid-block.
module tb_ref_line_builder;

    logic        CLK = 1'b0;
    logic        RST_ASYNC;
    logic        START;
    logic [63:0] ROW_IN;
    logic        ROW_VALID;
    logic        ROW_READY;
    logic [71:0] LINE_OUT;
    logic        LINE_WE;
    logic [3:0]  LINE_IDX;
    logic        BUSY;
    logic        DONE;

    ref_line_builder dut (
        .CLK(CLK), .RST_ASYNC(RST_ASYNC), .START(START), .ROW_IN(ROW_IN),
        .ROW_VALID(ROW_VALID), .ROW_READY(ROW_READY), .LINE_OUT(LINE_OUT),
        .LINE_WE(LINE_WE), .LINE_IDX(LINE_IDX), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneCount = 0;
    int doneCycle = 0;
    int lastWeCycle = 0;
    int startCyc = 0;
    logic [71:0] lineQ[$];
    logic [3:0]  idxQ[$];
    logic [63:0] rows[0:8];

    always @(posedge CLK) cyc++;

    // Lines and DONE are collected mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (!RST_ASYNC) begin
            if (LINE_WE) begin
                lineQ.push_back(LINE_OUT);
                idxQ.push_back(LINE_IDX);
                lastWeCycle = cyc;
            end
            if (DONE) begin
                doneCount++;
                doneCycle = cyc;
                total++;
                if (LINE_WE !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL done_excl: LINE_WE=%b alongside DONE, want 0", LINE_WE);
                end
            end
        end
    end

    function automatic logic [71:0] expLine(input int i);
        int k;
        k = (i == 0) ? 0 : i - 1;
        return {rows[k][63:56], rows[k]};
    endfunction

    task automatic applyStimulus(input bit toggle, input bit pokeStart, input int stopAfter,
                                 output bit timedOut);
        int k;
        bit hs;
        int d0;
        k = 0;
        hs = 1'b0;
        d0 = doneCount;
        timedOut = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            #1;
            if (hs) k++;
            if (doneCount != d0) begin
                timedOut = 1'b0;
                break;
            end
            if (stopAfter > 0 && lineQ.size() >= stopAfter) begin
                timedOut = 1'b0;
                break;
            end
            if (i == 0) startCyc = cyc;
            START     = (i == 0) || (pokeStart && BUSY && (i == 2 || i == 5));
            ROW_IN    = rows[(k > 8) ? 8 : k];
            ROW_VALID = toggle ? (i % 2 == 0) : 1'b1;
            hs        = ROW_VALID && ROW_READY;
        end
        START = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total += 6;
        if (LINE_WE !== 1'b0) begin bad++; $display("[TB] FAIL rst_we: got %b want 0", LINE_WE); end
        if (LINE_OUT !== 72'd0) begin bad++; $display("[TB] FAIL rst_out: got %h want 0", LINE_OUT); end
        if (LINE_IDX !== 4'd0) begin bad++; $display("[TB] FAIL rst_idx: got %0d want 0", LINE_IDX); end
        if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", BUSY); end
        if (DONE !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", DONE); end
        if (ROW_READY !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", ROW_READY); end
        @(negedge CLK);
        RST_ASYNC = 1'b0;
    endtask

    task automatic test_basic;
        bit to;
        int n;
        lineQ.delete();
        idxQ.delete();
        applyStimulus(1'b0, 1'b0, 0, to);
        ROW_VALID = 1'b0;
        n = (lineQ.size() < 9) ? lineQ.size() : 9;
        total += 4;
        if (to) begin bad++; $display("[TB] FAIL basic_timeout: no DONE within budget"); end
        if (lineQ.size() != 9) begin bad++; $display("[TB] FAIL basic_count: got %0d lines want 9", lineQ.size()); end
        if (doneCycle != lastWeCycle + 1) begin
            bad++; $display("[TB] FAIL basic_done_lat: DONE at %0d, last WE at %0d, want +1", doneCycle, lastWeCycle);
        end
        if (doneCycle - startCyc != 11) begin
            bad++; $display("[TB] FAIL basic_blocktime: got %0d cycles want 11", doneCycle - startCyc);
        end
        for (int i = 0; i < n; i++) begin
            total += 2;
            if (lineQ[i] !== expLine(i)) begin
                bad++; $display("[TB] FAIL basic_line%0d: got %h want %h", i, lineQ[i], expLine(i));
            end
            if (idxQ[i] !== 4'(i)) begin
                bad++; $display("[TB] FAIL basic_idx%0d: got %0d want %0d", i, idxQ[i], i);
            end
        end
        total += 1;
        if (lineQ.size() > 1 && lineQ[0] !== 72'h010102030405060708) begin
            bad++; $display("[TB] FAIL basic_line0_const: got %h want 010102030405060708", lineQ[0]);
        end
    endtask

    task automatic test_sign;
        bit to;
        rows[0] = 64'hFF00000000000000;
        lineQ.delete();
        idxQ.delete();
        applyStimulus(1'b0, 1'b0, 0, to);
        ROW_VALID = 1'b0;
        total += 3;
        if (to || lineQ.size() != 9) begin
            bad++; $display("[TB] FAIL sign_count: got %0d lines (timeout=%b) want 9", lineQ.size(), to);
        end
        if (lineQ.size() < 2 || lineQ[0] !== 72'hFFFF00000000000000) begin
            bad++; $display("[TB] FAIL sign_line0: got %h want ffff00000000000000", (lineQ.size() > 0) ? lineQ[0] : 72'd0);
        end
        if (lineQ.size() < 2 || lineQ[1] !== 72'hFFFF00000000000000) begin
            bad++; $display("[TB] FAIL sign_line1: got %h want ffff00000000000000", (lineQ.size() > 1) ? lineQ[1] : 72'd0);
        end
        rows[0] = 64'h0102030405060708;
    endtask

    task automatic test_toggle;
        bit to;
        int n;
        lineQ.delete();
        idxQ.delete();
        applyStimulus(1'b1, 1'b0, 0, to);
        ROW_VALID = 1'b0;
        n = (lineQ.size() < 9) ? lineQ.size() : 9;
        total += 2;
        if (to) begin bad++; $display("[TB] FAIL toggle_timeout: no DONE within budget"); end
        if (lineQ.size() != 9) begin bad++; $display("[TB] FAIL toggle_count: got %0d lines want 9", lineQ.size()); end
        for (int i = 0; i < n; i++) begin
            total += 2;
            if (lineQ[i] !== expLine(i)) begin
                bad++; $display("[TB] FAIL toggle_line%0d: got %h want %h", i, lineQ[i], expLine(i));
            end
            if (idxQ[i] !== 4'(i)) begin
                bad++; $display("[TB] FAIL toggle_idx%0d: got %0d want %0d", i, idxQ[i], i);
            end
        end
    endtask

    task automatic test_ignore;
        bit to;
        int d0;
        lineQ.delete();
        idxQ.delete();
        ROW_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        total += 1;
        if (lineQ.size() != 0 || BUSY !== 1'b0) begin
            bad++; $display("[TB] FAIL ignore_idle_valid: got %0d lines busy=%b want 0/0", lineQ.size(), BUSY);
        end
        d0 = doneCount;
        applyStimulus(1'b0, 1'b1, 0, to);
        START = 1'b1;
        @(negedge CLK);
        #1;
        START = 1'b0;
        ROW_VALID = 1'b0;
        total += 1;
        if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL ignore_start_on_done: busy=%b want 0", BUSY); end
        repeat (4) @(negedge CLK);
        #1;
        total += 3;
        if (to || lineQ.size() != 9) begin
            bad++; $display("[TB] FAIL ignore_count: got %0d lines (timeout=%b) want 9", lineQ.size(), to);
        end
        if (doneCount != d0 + 1) begin
            bad++; $display("[TB] FAIL ignore_done_count: got %0d want %0d", doneCount - d0, 1);
        end
        if (lineQ.size() == 9 && lineQ[8] !== expLine(8)) begin
            bad++; $display("[TB] FAIL ignore_line8: got %h want %h", lineQ[8], expLine(8));
        end
    endtask

    task automatic test_mid_reset;
        bit to;
        int d0;
        int n;
        lineQ.delete();
        idxQ.delete();
        applyStimulus(1'b0, 1'b0, 5, to);
        @(posedge CLK);
        #2;
        RST_ASYNC = 1'b1;
        #1;
        total += 5;
        if (LINE_WE !== 1'b0) begin bad++; $display("[TB] FAIL mid_we: got %b want 0", LINE_WE); end
        if (LINE_OUT !== 72'd0) begin bad++; $display("[TB] FAIL mid_out: got %h want 0", LINE_OUT); end
        if (LINE_IDX !== 4'd0) begin bad++; $display("[TB] FAIL mid_idx: got %0d want 0", LINE_IDX); end
        if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b want 0", BUSY); end
        if (ROW_READY !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got %b want 0", ROW_READY); end
        @(negedge CLK);
        #1;
        RST_ASYNC = 1'b0;
        lineQ.delete();
        idxQ.delete();
        d0 = doneCount;
        repeat (5) @(negedge CLK);
        #1;
        total += 1;
        if (lineQ.size() != 0 || doneCount != d0) begin
            bad++; $display("[TB] FAIL mid_quiet: got %0d lines %0d dones want 0/0", lineQ.size(), doneCount - d0);
        end
        applyStimulus(1'b0, 1'b0, 0, to);
        ROW_VALID = 1'b0;
        n = (lineQ.size() < 9) ? lineQ.size() : 9;
        total += 1;
        if (to || lineQ.size() != 9) begin
            bad++; $display("[TB] FAIL mid_recover_count: got %0d lines (timeout=%b) want 9", lineQ.size(), to);
        end
        for (int i = 0; i < n; i++) begin
            total += 1;
            if (lineQ[i] !== expLine(i) || idxQ[i] !== 4'(i)) begin
                bad++; $display("[TB] FAIL mid_recover_line%0d: got %h/%0d want %h/%0d", i, lineQ[i], idxQ[i], expLine(i), i);
            end
        end
    endtask

    initial begin
        RST_ASYNC = 1'b1;
        START     = 1'b0;
        ROW_VALID = 1'b0;
        ROW_IN    = 64'd0;
        for (int k = 0; k <= 8; k++) begin
            rows[k] = 64'h0102030405060708 + 64'(k) * 64'h1010101010101010;
        end
        test_reset;
        test_basic;
        test_sign;
        test_toggle;
        test_ignore;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
